// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, R/W and ACK bit
// meanings, and a 3-input majority helper used by the optional glitch filter.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA front end: two-flop synchronizers, optional 3-sample majority filter
// (enabled by I2C_TGT_GLITCH_FILTER_EN), SCL edge and START/STOP detection.
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_d;
  logic       r_sda_d;
  logic       w_scl_f;
  logic       w_sda_f;

  // Two-flop synchronizers, preset high so reset looks like an idle bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl};
      r_sda_sync <= {r_sda_sync[0], sda};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist;
  logic [1:0] r_sda_hist;
  logic       r_scl_maj;
  logic       r_sda_maj;

  // Majority of the last three synced samples swallows single-clk spikes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_maj  <= 1'b1;
      r_sda_maj  <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
      r_scl_maj  <= maj3(r_scl_sync[1], r_scl_hist[0], r_scl_hist[1]);
      r_sda_maj  <= maj3(r_sda_sync[1], r_sda_hist[0], r_sda_hist[1]);
    end
  end

  assign w_scl_f = r_scl_maj;
  assign w_sda_f = r_sda_maj;
`else
  assign w_scl_f = r_scl_sync[1];
  assign w_sda_f = r_sda_sync[1];
`endif

  // Delayed copies of the clean levels for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl_f;
      r_sda_d <= w_sda_f;
    end
  end

  assign scl_rise  = w_scl_f & ~r_scl_d;
  assign scl_fall  = ~w_scl_f & r_scl_d;
  assign start_det = w_scl_f & r_scl_d & r_sda_d & ~w_sda_f;
  assign stop_det  = w_scl_f & r_scl_d & ~r_sda_d & w_sda_f;
  assign sda_s     = w_sda_f;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a small byte register file. The first written byte sets the
// pointer, later bytes write data, reads stream data; the pointer wraps.
// Optional input glitch filter: define I2C_TGT_GLITCH_FILTER_EN.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'b1010101,
  parameter int         REG_AW   = 2,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i2c_scl,
  inout  wire                       i2c_sda,
  output logic [8*(2**REG_AW)-1:0]  regs_flat,
  output logic                      wr_strobe,
  output logic [REG_AW-1:0]         wr_ptr,
  output logic                      busy
);

  localparam int NUM_REGS = 2**REG_AW;

  logic              w_scl_rise;
  logic              w_scl_fall;
  logic              w_start;
  logic              w_stop;
  logic              w_sda_s;

  state_t            r_state;
  state_t            w_state_nx;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nx;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_nx;
  logic              r_sda_low;
  logic              w_sda_low_nx;
  logic [REG_AW-1:0] r_ptr;
  logic [REG_AW-1:0] w_ptr_nx;
  logic [REG_AW-1:0] w_ptr_inc;
  logic              r_first;
  logic              w_first_nx;
  logic              r_busy;
  logic              w_busy_nx;
  logic              r_wr_strobe;
  logic              w_wr_strobe_nx;
  logic [REG_AW-1:0] r_wr_ptr;
  logic [REG_AW-1:0] w_wr_ptr_nx;
  logic              w_reg_we;
  logic [7:0]        w_byte;
  logic [7:0]        r_regs [NUM_REGS];

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (i2c_scl),
    .sda       (i2c_sda),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop),
    .sda_s     (w_sda_s)
  );

  assign i2c_sda   = r_sda_low ? 1'b0 : 1'bz;
  assign w_ptr_inc = r_ptr + 1'b1;
  assign w_byte    = {r_shift[6:0], w_sda_s};
  assign wr_strobe = r_wr_strobe;
  assign wr_ptr    = r_wr_ptr;
  assign busy      = r_busy;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_flat[8*k +: 8] = r_regs[k];
  end

  // FSM and datapath registers; reset releases SDA at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_shift     <= 8'h00;
      r_sda_low   <= 1'b0;
      r_ptr       <= '0;
      r_first     <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_ptr    <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_shift     <= w_shift_nx;
      r_sda_low   <= w_sda_low_nx;
      r_ptr       <= w_ptr_nx;
      r_first     <= w_first_nx;
      r_busy      <= w_busy_nx;
      r_wr_strobe <= w_wr_strobe_nx;
      r_wr_ptr    <= w_wr_ptr_nx;
    end
  end

  // Register file write port, fed by the committed data byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RST_VAL;
    end else if (w_reg_we) begin
      r_regs[r_ptr] <= w_byte;
    end
  end

  // Next-state logic; START/STOP override any data edge in the same clk
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_shift_nx     = r_shift;
    w_sda_low_nx   = r_sda_low;
    w_ptr_nx       = r_ptr;
    w_first_nx     = r_first;
    w_busy_nx      = r_busy;
    w_wr_strobe_nx = 1'b0;
    w_wr_ptr_nx    = r_wr_ptr;
    w_reg_we       = 1'b0;
    if (w_start) begin
      w_state_nx   = ADDR;
      w_cnt_nx     = 4'd0;
      w_sda_low_nx = 1'b0;
    end else if (w_stop) begin
      w_state_nx   = IDLE;
      w_cnt_nx     = 4'd0;
      w_sda_low_nx = 1'b0;
      w_busy_nx    = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_sda_low_nx = 1'b0;
        end
        ADDR: begin
          if (w_scl_rise) begin
            w_shift_nx = w_byte;
            w_cnt_nx   = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_cnt_nx = 4'd0;
            if (r_shift[7:1] == DEV_ADDR) begin
              w_state_nx   = ADDR_ACK;
              w_sda_low_nx = 1'b1;
              w_busy_nx    = 1'b1;
            end else begin
              w_state_nx = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (w_scl_fall) begin
            w_cnt_nx = 4'd0;
            if (r_shift[0] == RW_WRITE) begin
              w_state_nx   = WR_BYTE;
              w_first_nx   = 1'b1;
              w_sda_low_nx = 1'b0;
            end else begin
              w_state_nx   = RD_BYTE;
              w_shift_nx   = r_regs[r_ptr];
              w_sda_low_nx = ~r_regs[r_ptr][7];
            end
          end
        end
        WR_BYTE: begin
          if (w_scl_rise) begin
            w_shift_nx = w_byte;
            w_cnt_nx   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              if (r_first) begin
                w_ptr_nx   = w_byte[REG_AW-1:0];
                w_first_nx = 1'b0;
              end else begin
                w_reg_we       = 1'b1;
                w_wr_strobe_nx = 1'b1;
                w_wr_ptr_nx    = r_ptr;
                w_ptr_nx       = w_ptr_inc;
              end
            end
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_state_nx   = WR_ACK;
            w_sda_low_nx = 1'b1;
            w_cnt_nx     = 4'd0;
          end
        end
        WR_ACK: begin
          if (w_scl_fall) begin
            w_state_nx   = WR_BYTE;
            w_sda_low_nx = 1'b0;
            w_cnt_nx     = 4'd0;
          end
        end
        RD_BYTE: begin
          if (w_scl_rise) begin
            w_cnt_nx = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_state_nx   = RD_ACK;
              w_sda_low_nx = 1'b0;
              w_cnt_nx     = 4'd0;
            end else if (r_cnt == 4'd0) begin
              w_sda_low_nx = ~r_shift[7];
            end else begin
              w_shift_nx   = {r_shift[6:0], 1'b0};
              w_sda_low_nx = ~r_shift[6];
            end
          end
        end
        RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda_s == ACK) begin
              w_ptr_nx   = w_ptr_inc;
              w_shift_nx = r_regs[w_ptr_inc];
              w_state_nx = RD_BYTE;
              w_cnt_nx   = 4'd0;
            end else begin
              w_state_nx = IGNORE;
            end
          end
        end
        IGNORE: begin
          w_sda_low_nx = 1'b0;
        end
        default: begin
          w_state_nx   = IDLE;
          w_sda_low_nx = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: a bit-banged I2C master drives the
// bus and every result is compared against hand-computed values.
module tb_i2c_target_regfile;
  import i2c_pkg::*;

  localparam int QTR = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        mSdaLow;
  wire         sda;
  logic [31:0] regsFlat;
  logic        wrStrobe;
  logic [1:0]  wrPtr;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          strobeCount = 0;
  logic [1:0]  strobePtr [0:15];
  logic        ackBit;
  logic [7:0]  rdData;

  assign sda = mSdaLow ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_target_regfile #(
    .DEV_ADDR (7'b1010101),
    .REG_AW   (2),
    .RST_VAL  (8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i2c_scl   (scl),
    .i2c_sda   (sda),
    .regs_flat (regsFlat),
    .wr_strobe (wrStrobe),
    .wr_ptr    (wrPtr),
    .busy      (busy)
  );

  // Record every write strobe and its pointer, sampled away from the active edge
  always @(negedge clk) begin
    if (wrStrobe) begin
      strobePtr[strobeCount[3:0]] = wrPtr;
      strobeCount = strobeCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sclVal, input logic sdaLowVal);
    scl     = sclVal;
    mSdaLow = sdaLowVal;
    #QTR;
  endtask

  task automatic clockBit(input logic sendLow, output logic sampled);
    applyStimulus(1'b0, mSdaLow);
    applyStimulus(1'b0, sendLow);
    applyStimulus(1'b1, sendLow);
    sampled = sda;
    applyStimulus(1'b1, sendLow);
  endtask

  task automatic busStart();
    applyStimulus(1'b0, mSdaLow);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
  endtask

  task automatic busStop();
    applyStimulus(1'b0, mSdaLow);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
  endtask

  task automatic busWriteByte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(~b[i], s);
    clockBit(1'b0, ack);
  endtask

  task automatic busReadByte(input logic masterAck, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b0, s);
      d[i] = s;
    end
    clockBit(masterAck == ACK, s);
  endtask

  initial begin
    rst     = 1'b0;
    scl     = 1'b1;
    mSdaLow = 1'b0;
    #2;
    #(2*QTR);
    checkOutput("reset sda released", {31'b0, sda}, 32'd1);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    rst = 1'b1;
    #QTR;
    $display("[TB] test 1: idle after reset");
    checkOutput("idle sda released", {31'b0, sda}, 32'd1);
    checkOutput("idle busy", {31'b0, busy}, 32'd0);
    checkOutput("idle regs", regsFlat, 32'h0);
    checkOutput("idle no strobe", strobeCount, 32'd0);

    $display("[TB] test 2: pointer-only write");
    busStart();
    busWriteByte(8'hAA, ackBit);
    checkOutput("t2 addr ack", {31'b0, ackBit}, 32'd0);
    checkOutput("t2 busy", {31'b0, busy}, 32'd1);
    busWriteByte(8'hAA, ackBit);
    checkOutput("t2 data ack", {31'b0, ackBit}, 32'd0);
    checkOutput("t2 ptr", {30'b0, dut.r_ptr}, 32'd2);
    busStop();
    checkOutput("t2 busy after stop", {31'b0, busy}, 32'd0);
    checkOutput("t2 regs unchanged", regsFlat, 32'h0);
    checkOutput("t2 no strobe", strobeCount, 32'd0);

    $display("[TB] test 3: data writes with pointer wrap");
    busStart();
    busWriteByte(8'hAA, ackBit);
    checkOutput("t3 addr ack", {31'b0, ackBit}, 32'd0);
    busWriteByte(8'h01, ackBit);
    checkOutput("t3 ptr ack", {31'b0, ackBit}, 32'd0);
    busWriteByte(8'h11, ackBit);
    checkOutput("t3 d0 ack", {31'b0, ackBit}, 32'd0);
    busWriteByte(8'h22, ackBit);
    busWriteByte(8'h33, ackBit);
    busWriteByte(8'h44, ackBit);
    checkOutput("t3 d3 ack", {31'b0, ackBit}, 32'd0);
    busStop();
    checkOutput("t3 regs", regsFlat, 32'h33221144);
    checkOutput("t3 strobe count", strobeCount, 32'd4);
    checkOutput("t3 strobe ptr0", {30'b0, strobePtr[0]}, 32'd1);
    checkOutput("t3 strobe ptr1", {30'b0, strobePtr[1]}, 32'd2);
    checkOutput("t3 strobe ptr2", {30'b0, strobePtr[2]}, 32'd3);
    checkOutput("t3 strobe ptr3", {30'b0, strobePtr[3]}, 32'd0);

    $display("[TB] test 4: repeated START read with wrap");
    busStart();
    busWriteByte(8'hAA, ackBit);
    busWriteByte(8'h03, ackBit);
    checkOutput("t4 ptr ack", {31'b0, ackBit}, 32'd0);
    busStart();
    busWriteByte(8'hAB, ackBit);
    checkOutput("t4 read addr ack", {31'b0, ackBit}, 32'd0);
    busReadByte(ACK, rdData);
    checkOutput("t4 read reg3", {24'b0, rdData}, 32'h33);
    busReadByte(NACK, rdData);
    checkOutput("t4 read reg0", {24'b0, rdData}, 32'h44);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t4 sda released after nack", {31'b0, sda}, 32'd1);
    checkOutput("t4 state ignore", 32'(dut.r_state), 32'(IGNORE));
    busStop();
    checkOutput("t4 busy after stop", {31'b0, busy}, 32'd0);
    checkOutput("t4 no extra strobe", strobeCount, 32'd4);

    $display("[TB] test 5: foreign address ignored");
    busStart();
    busWriteByte(8'hA8, ackBit);
    checkOutput("t5 no ack", {31'b0, ackBit}, 32'd1);
    checkOutput("t5 busy", {31'b0, busy}, 32'd0);
    checkOutput("t5 state ignore", 32'(dut.r_state), 32'(IGNORE));
    busWriteByte(8'h00, ackBit);
    checkOutput("t5 data not acked", {31'b0, ackBit}, 32'd1);
    busStop();
    checkOutput("t5 regs unchanged", regsFlat, 32'h33221144);
    checkOutput("t5 no strobe", strobeCount, 32'd4);

    $display("[TB] test 6: reset while driving a read 0 bit");
    busStart();
    busWriteByte(8'hAB, ackBit);
    checkOutput("t6 read addr ack", {31'b0, ackBit}, 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t6 driving bit7 low", {31'b0, sda}, 32'd0);
    checkOutput("t6 busy", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("t6 sda released by reset", {31'b0, sda}, 32'd1);
    checkOutput("t6 state idle", 32'(dut.r_state), 32'(IDLE));
    checkOutput("t6 regs reset", regsFlat, 32'h0);
    checkOutput("t6 busy reset", {31'b0, busy}, 32'd0);
    applyStimulus(1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t6 idle sda", {31'b0, sda}, 32'd1);
    checkOutput("t6 idle busy", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- I2C target (responder) that answers the codebase's i2c_master on the shared i2c_sda/i2c_scl bus.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, and ACKs.
- Serves a small byte register file: first written byte sets the register pointer, later bytes write data, reads stream data; the pointer auto-increments.
- Sits beside i2c_master in the bus-level benches and on FPGA as an on-chip I2C-accessible config block.

Parameters:
- DEV_ADDR, 7'b1010101, target address compared against the first byte [7:1].
- REG_AW, 2, register pointer width; NUM_REGS = 2**REG_AW bytes.
- RST_VAL, 8'h00, reset value of every register byte.

Ports:
- clk  input  1  system clock; SCL high and low phases are each at least 4 clk periods.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- i2c_scl  input  1  bus clock; the target never stretches it.
- i2c_sda  inout  1  open-drain data: driven 0 or released (z), never driven 1.
- regs_flat  output  8*NUM_REGS  register file; byte k is at [8k+7:8k].
- wr_strobe  output  1  one-clk pulse when a data byte is committed.
- wr_ptr  output  REG_AW  register index of the committed byte; valid with wr_strobe.
- busy  output  1  high from an addressed START until STOP.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, sda released, all registers=RST_VAL, pointer=0.
  - wr_strobe=0, busy=0, synchronizers preset to 1 (idle bus).
- Input sync: scl and sda each pass through 2 flops. The edge detector compares the synced value with a delayed copy. Detection latency is 3 clk.
- START = sda falling while scl high. Valid in any state (repeated START included). Effect: enter ADDR, bit count=0.
- STOP = sda rising while scl high. Valid in any state. Effect: enter IDLE, release sda, busy=0.
- Data sampling and driving:
  - Sample sda on scl rising edge, MSB first.
  - Change the sda drive only on scl falling edge, one clk after detection.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. If [7:1]==DEV_ADDR, go to ADDR_ACK and set busy=1. Otherwise go to IGNORE.
  - ADDR_ACK: pull sda low for the 9th bit. On the falling edge after it:
    - rw=0 goes to WR_BYTE with first_byte flag set.
    - rw=1 goes to RD_BYTE and loads the shift register from regs[ptr].
  - WR_BYTE: shift 8 bits, then go to WR_ACK and pull sda low.
    - If first_byte: ptr = byte[REG_AW-1:0] and clear first_byte.
    - Else: regs[ptr] = byte, pulse wr_strobe with wr_ptr=ptr, then ptr = ptr+1 (wraps mod NUM_REGS).
    - Commit happens on the 8th scl rising edge.
  - WR_ACK: release sda on the falling edge after the 9th bit, return to WR_BYTE.
  - RD_BYTE: drive each bit on the scl falling edge (bit 7 first, driven right after the ACK falling edge). Bit 1 = release, bit 0 = drive low. After 8 bits, release sda and go to RD_ACK.
  - RD_ACK: sample master ACK on scl rising edge.
    - ACK (0): ptr = ptr+1 (wraps), reload the shift register, return to RD_BYTE.
    - NACK (1): go to IGNORE until STOP/START.
  - IGNORE: sda released; only START/STOP are recognised.
- Pointer wraps NUM_REGS-1 to 0 for both reads and writes.
- Simultaneous conditions: if START/STOP is detected in the same clk as a data edge, START/STOP wins and no partial byte is committed.
- Reset mid-transfer releases sda immediately, combinationally via the async reset.

Optional Feature:
- Macro: I2C_TGT_GLITCH_FILTER_EN.
- When defined: after the 2-flop sync, scl and sda each pass through a 3-sample majority filter. This suppresses single-clk spikes, adds 2 clk latency, and raises the minimum SCL phase to 6 clk.
- When undefined: no filter; behaviour exactly as above.

Decomposition:
- Shared package i2c_pkg holds:
  - state encoding constants (IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE);
  - RW_WRITE=0 and RW_READ=1;
  - ACK=0 and NACK=1.
- One sub-module, i2c_bus_sync: synchronizer, optional filter and edge/START/STOP detector.
  - Inputs: scl, sda.
  - Outputs: scl_rise, scl_fall, start_det, stop_det, sda_s.
- The FSM and register file stay in the top module.

Test Plan:
1. Reset hold, then release with bus idle → sda z, busy=0, regs_flat=0, no wr_strobe.
2. i2c_master write, addr 7'b1010101, data 8'hAA → address ACKed, ptr=2 (8'hAA[1:0]), no register write, busy falls after STOP.
3. Bus-model write 0x55→ptr 0x01, then 0x11, 0x22, 0x33, 0x44 → writes to regs 1,2,3,0 (pointer wraps), regs_flat=32'h33221144, four wr_strobe pulses with wr_ptr 1,2,3,0.
4. Write ptr 0x03, repeated START, read 2 bytes (ACK then NACK) → returns regs[3] then regs[0], sda released after NACK.
5. Address 7'b1010100 → no ACK (sda stays z for 9th bit), IGNORE until STOP, regs unchanged.
6. Assert rst while the target drives a read 0 bit → sda z within the same clk, state IDLE, regs back to 0.
